// File: rtl/rom_uart_streamer_if.sv
// Command, ROM and UART-side signals of the ROM-to-UART streamer.
// The streamer takes the slave modport; the surrounding logic or bench takes master.
interface rom_uart_streamer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              i_start;
  logic [ADDR_W-1:0] i_base;
  logic [ADDR_W:0]   i_len;
  logic              i_stop;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [DATA_W-1:0] i_rom_q;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_tx_vld;
  logic              i_tx_busy;

  modport slave (
    input  i_start, i_base, i_len, i_stop, i_rom_q, i_tx_busy,
    output o_busy, o_done, o_rom_addr, o_tx_data, o_tx_vld
  );

  modport master (
    output i_start, i_base, i_len, i_stop, i_rom_q, i_tx_busy,
    input  o_busy, o_done, o_rom_addr, o_tx_data, o_tx_vld
  );
endinterface

// File: rtl/rom_uart_streamer.sv
// Streams i_len bytes from a synchronous ROM starting at i_base into uart_tx,
// one byte per UART frame; i_stop ends the transfer after the byte in flight.
module rom_uart_streamer #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  rom_uart_streamer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_Q, SEND, WAIT_TX, DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W:0]   rem_q;
  logic [1:0]        lat_q;
  logic              guard_q;
  logic              stop_q;
  logic              busy_q;
  logic              done_q;
  logic              tx_vld_q;
  logic [DATA_W-1:0] tx_data_q;

  logic stop_now;
  logic to_done;

  // A stop seen before the strobe abandons the pending byte; once sent, it waits for the frame.
  always_comb begin
    stop_now = stop_q | bus.i_stop;
    to_done  = 1'b0;
    if (state_q inside {FETCH, WAIT_Q, SEND}) begin
      to_done = stop_now;
    end else if (state_q == WAIT_TX) begin
      to_done = !guard_q && !bus.i_tx_busy && ((rem_q == '0) || stop_now);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rom_addr_q <= '0;
      rem_q      <= '0;
      lat_q      <= '0;
      guard_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_vld_q   <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_vld_q <= 1'b0;
      done_q   <= 1'b0;
      if (state_q != IDLE && bus.i_stop) begin
        stop_q <= 1'b1;
      end
      if (to_done) begin
        state_q <= DONE;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            stop_q <= 1'b0;
            if (bus.i_start) begin
              addr_q <= bus.i_base;
              rem_q  <= bus.i_len;
              if (bus.i_len == '0) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= FETCH;
                busy_q  <= 1'b1;
              end
            end
          end
          FETCH: begin
            rom_addr_q <= addr_q;
            lat_q      <= 2'(ROM_LAT - 1);
            state_q    <= WAIT_Q;
          end
          WAIT_Q: begin
            if (lat_q == 2'd0) begin
              state_q <= SEND;
            end else begin
              lat_q <= lat_q - 2'd1;
            end
          end
          SEND: begin
            if (!bus.i_tx_busy) begin
              tx_data_q <= bus.i_rom_q;
              tx_vld_q  <= 1'b1;
              addr_q    <= addr_q + 1'b1;
              rem_q     <= rem_q - 1'b1;
              guard_q   <= 1'b1;
              state_q   <= WAIT_TX;
            end
          end
          WAIT_TX: begin
            // uart_tx only raises busy the cycle after the strobe, so skip one cycle.
            guard_q <= 1'b0;
            if (!guard_q && !bus.i_tx_busy) begin
              state_q <= FETCH;
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_rom_addr = rom_addr_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_vld   = tx_vld_q;

endmodule

// File: tb/tb_rom_uart_streamer.sv
// Directed bench: three streamers with ROM_LAT 1/2/3 (ROM[a] = a[7:0]), UART busy
// 20 cycles per byte; index 1 (ROM_LAT=2) carries the detailed scenarios.
module tb_rom_uart_streamer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_m = '0;
  logic [9:0]  base = '0;
  logic [10:0] len = '0;
  logic        stop = 1'b0;
  logic        hold = 1'b0;
  logic        clr = 1'b1;

  logic [2:0]  vld_v, done_v, busy_v;
  logic [7:0]  txd_v [3];
  logic [9:0]  ra_v [3];
  int          bcnt [3];
  int          nvld [3];
  int          ndone [3];
  logic [7:0]  logd [3][16];
  logic [9:0]  loga [3][16];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_lat
    rom_uart_streamer_if #(.ADDR_W(10), .DATA_W(8)) bus ();
    logic [7:0] pipe [3];

    always @(posedge clk) begin
      pipe[0] <= bus.o_rom_addr[7:0];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    assign bus.i_start   = start_m[gi];
    assign bus.i_base    = base;
    assign bus.i_len     = len;
    assign bus.i_stop    = stop;
    assign bus.i_rom_q   = pipe[gi];
    assign bus.i_tx_busy = (bcnt[gi] != 0) || ((gi == 1) && hold);
    assign vld_v[gi]     = bus.o_tx_vld;
    assign done_v[gi]    = bus.o_done;
    assign busy_v[gi]    = bus.o_busy;
    assign txd_v[gi]     = bus.o_tx_data;
    assign ra_v[gi]      = bus.o_rom_addr;

    rom_uart_streamer #(.ADDR_W(10), .DATA_W(8), .ROM_LAT(gi + 1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  // UART model and byte/done logger for all three instances.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vld_v[k]) bcnt[k] <= 20;
      else if (bcnt[k] != 0) bcnt[k] <= bcnt[k] - 1;
      if (clr) begin
        nvld[k]  <= 0;
        ndone[k] <= 0;
      end else begin
        if (vld_v[k]) begin
          if (nvld[k] < 16) begin
            logd[k][nvld[k]] <= txd_v[k];
            loga[k][nvld[k]] <= ra_v[k];
          end
          nvld[k] <= nvld[k] + 1;
        end
        if (done_v[k]) ndone[k] <= ndone[k] + 1;
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) bcnt[k] = 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

  task automatic go(input logic [2:0] m, input logic [9:0] b, input logic [10:0] l);
    base = b;
    len = l;
    start_m = m;
    cyc(1);
    start_m = '0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    logic seen = 1'b0;
    logic held = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (done_v[1]) begin
        seen = 1'b1;
        break;
      end
      if (!busy_v[1]) held = 1'b0;
      cyc(1);
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_held"}, 32'(held), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_v[1]), 32'd0);
    cyc(1);
    chk({tag, "_done_1cyc"}, 32'(done_v[1]), 32'd0);
  endtask

  task automatic check_bytes(input string tag, input int k, input int n, input logic [9:0] b);
    logic [9:0] a;
    chk({tag, "_nbytes"}, 32'(nvld[k]), 32'(n));
    chk({tag, "_ndone"}, 32'(ndone[k]), 32'd1);
    for (int j = 0; j < n; j++) begin
      a = b + 10'(j);
      chk({tag, "_addr"}, 32'(loga[k][j]), 32'(a));
      chk({tag, "_data"}, 32'(logd[k][j]), 32'(a[7:0]));
    end
  endtask

  initial begin
    int nb;
    logic found;

    cyc(3);
    chk("rst_busy", 32'(busy_v), 32'd0);
    chk("rst_done", 32'(done_v), 32'd0);
    chk("rst_vld", 32'(vld_v), 32'd0);
    chk("rst_addr", 32'(ra_v[1]), 32'd0);
    chk("rst_data", 32'(txd_v[1]), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    clr = 1'b0;

    // 1: four bytes from 0x010, first strobe 5 edges after start is sampled
    clear_log();
    go(3'b010, 10'h010, 11'd4);
    chk("t1_busy_after_start", 32'(busy_v[1]), 32'd1);
    cyc(4);
    chk("t1_first_vld", 32'(vld_v[1]), 32'd1);
    chk("t1_first_data", 32'(txd_v[1]), 32'h10);
    wait_done("t1", 500);
    check_bytes("t1", 1, 4, 10'h010);

    // 2: wrap past the top of the ROM; simultaneous stop in IDLE is ignored
    clear_log();
    stop = 1'b1;
    go(3'b010, 10'h3FE, 11'd4);
    stop = 1'b0;
    wait_done("t2", 500);
    check_bytes("t2", 1, 4, 10'h3FE);

    // 3: zero-length transfer
    clear_log();
    go(3'b010, 10'h055, 11'd0);
    chk("t3_done", 32'(done_v[1]), 32'd1);
    chk("t3_busy", 32'(busy_v[1]), 32'd0);
    cyc(1);
    chk("t3_done_1cyc", 32'(done_v[1]), 32'd0);
    chk("t3_busy_after", 32'(busy_v[1]), 32'd0);
    cyc(5);
    chk("t3_nbytes", 32'(nvld[1]), 32'd0);
    chk("t3_ndone", 32'(ndone[1]), 32'd1);

    // 4: stop during the third WAIT_TX leaves exactly three bytes
    clear_log();
    go(3'b010, 10'h020, 11'd8);
    nb = 0;
    for (int i = 0; i < 500; i++) begin
      if (vld_v[1]) nb++;
      if (nb == 3) break;
      cyc(1);
    end
    chk("t4_third_vld", 32'(nb), 32'd3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    wait_done("t4", 500);
    check_bytes("t4", 1, 3, 10'h020);

    // 5: UART busy held at SEND; stray start ignored
    clear_log();
    hold = 1'b1;
    go(3'b010, 10'h040, 11'd2);
    cyc(10);
    go(3'b010, 10'h100, 11'd5);
    cyc(38);
    chk("t5_no_strobe", 32'(nvld[1]), 32'd0);
    chk("t5_busy_in_hold", 32'(busy_v[1]), 32'd1);
    hold = 1'b0;
    wait_done("t5", 500);
    check_bytes("t5", 1, 2, 10'h040);

    // 6: reset while waiting on ROM data for byte 2
    clear_log();
    go(3'b010, 10'h080, 11'd4);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (ra_v[1] == 10'h081) begin
        found = 1'b1;
        break;
      end
      cyc(1);
    end
    chk("t6_reach_byte2", 32'(found), 32'd1);
    rst_n = 1'b0;
    cyc(1);
    chk("t6_busy", 32'(busy_v[1]), 32'd0);
    chk("t6_vld", 32'(vld_v[1]), 32'd0);
    chk("t6_addr", 32'(ra_v[1]), 32'd0);
    chk("t6_data", 32'(txd_v[1]), 32'd0);
    chk("t6_done", 32'(done_v[1]), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    chk("t6_no_done", 32'(ndone[1]), 32'd0);
    chk("t6_one_byte", 32'(nvld[1]), 32'd1);
    clear_log();
    go(3'b010, 10'h0F0, 11'd3);
    wait_done("t6b", 500);
    check_bytes("t6b", 1, 3, 10'h0F0);

    // ROM latency sweep: all three instances stream the same window
    clear_log();
    go(3'b111, 10'h1C0, 11'd3);
    cyc(400);
    for (int k = 0; k < 3; k++) begin
      check_bytes("sweep", k, 3, 10'h1C0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
